alu_mult_seq: RTL and testbench

Multi-cycle unsigned 16x16 multiply sequencer that drives the shared `alu` through shift-and-add. It holds the partial product, multiplicand and multiplier internally and issues one ALU operation per cycle: an add in one cycle, then a shift in the next. It sits beside the execute stage and owns the ALU's control inputs while `busy` is high. It returns the low 16 bits of the product plus an unsigned-overflow flag.

---
 rtl/alu_mult_seq.sv | 135 +++++++++++++
 tb/tb_alu_mult_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_seq.sv
// Sequential 16x16 unsigned shift-and-add multiplier driving the shared ALU.
// Define MULT_EARLY_EXIT_EN to finish as soon as the multiplier runs out of set bits.
module alu_mult_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] opA,
  input  logic [15:0] opB,
  output logic        busy,
  output logic        done,
  output logic [15:0] product,
  output logic        ovf,
  output logic [15:0] alu_A,
  output logic [15:0] alu_B,
  output logic [3:0]  alu_Op,
  output logic        alu_Cin,
  output logic        alu_invA,
  output logic        alu_invB,
  output logic        alu_sign,
  input  logic [15:0] alu_Out,
  input  logic        alu_Ofl
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_SHIFT,
    S_DONE
  } state_t;

  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SLL = 4'h1;

  state_t      state;
  logic [15:0] p_q;
  logic [15:0] m_q;
  logic [15:0] q_q;
  logic [4:0]  cnt_q;
  logic        ovf_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] q_sh;
  logic        last;

  assign q_sh = q_q >> 1;

`ifdef MULT_EARLY_EXIT_EN
  assign last = (q_sh == 16'h0) || (cnt_q == 5'd15);
`else
  assign last = (cnt_q == 5'd15);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      p_q    <= '0;
      m_q    <= '0;
      q_q    <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            p_q    <= '0;
            m_q    <= opA;
            q_q    <= opB;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= S_ADD;
          end
        end
        S_ADD: begin
          if (q_q[0]) begin
            p_q   <= alu_Out;
            ovf_q <= ovf_q | alu_Ofl;
          end
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          m_q   <= alu_Out;
          q_q   <= q_sh;
          cnt_q <= cnt_q + 5'd1;
          // a multiplicand bit leaving the top would still be added later
          if (m_q[15] && (q_sh != 16'h0))
            ovf_q <= 1'b1;
          if (last) begin
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            state <= S_ADD;
          end
        end
        S_DONE: begin
          done_q <= 1'b0;
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    alu_A  = '0;
    alu_B  = '0;
    alu_Op = '0;
    unique case (state)
      S_ADD: begin
        alu_A  = p_q;
        alu_B  = m_q;
        alu_Op = OP_ADD;
      end
      S_SHIFT: begin
        alu_A  = m_q;
        alu_B  = 16'h0001;
        alu_Op = OP_SLL;
      end
      default: ;
    endcase
  end

  assign alu_Cin  = 1'b0;
  assign alu_invA = 1'b0;
  assign alu_invB = 1'b0;
  assign alu_sign = 1'b0;
  assign busy     = busy_q;
  assign done     = done_q;
  assign product  = p_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_alu_mult_seq.sv
// Bench for alu_mult_seq: ALU stand-in, arithmetic reference model,
// per-cycle compare, directed literal cases and random traffic.
module tb_alu_mult_seq;

`ifdef MULT_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] opA = '0;
  logic [15:0] opB = '0;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        ovf;
  logic [15:0] alu_A;
  logic [15:0] alu_B;
  logic [3:0]  alu_Op;
  logic        alu_Cin;
  logic        alu_invA;
  logic        alu_invB;
  logic        alu_sign;
  logic [15:0] alu_Out;
  logic        alu_Ofl;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_mult_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .opA      (opA),
    .opB      (opB),
    .busy     (busy),
    .done     (done),
    .product  (product),
    .ovf      (ovf),
    .alu_A    (alu_A),
    .alu_B    (alu_B),
    .alu_Op   (alu_Op),
    .alu_Cin  (alu_Cin),
    .alu_invA (alu_invA),
    .alu_invB (alu_invB),
    .alu_sign (alu_sign),
    .alu_Out  (alu_Out),
    .alu_Ofl  (alu_Ofl)
  );

  // shared ALU stand-in: unsigned add with carry as overflow, shift left
  always_comb begin
    alu_Out = '0;
    alu_Ofl = 1'b0;
    case (alu_Op)
      4'h4: {alu_Ofl, alu_Out} = {1'b0, alu_A} + {1'b0, alu_B};
      4'h1: alu_Out = alu_A << alu_B[3:0];
      default: ;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lat_of(input logic [15:0] b);
    int k;
    k = 1;
    for (int i = 0; i < 16; i++)
      if (b[i]) k = i + 1;
    return EE ? 2 * k + 1 : 33;
  endfunction

  // reference model: cycle index since accepted start, operands, held result
  int          mt = 0;
  int          lat = 33;
  logic [15:0] ma = '0;
  logic [15:0] mb = '0;
  logic [15:0] hold_p = '0;
  logic        hold_o = 1'b0;
  logic [31:0] full;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mt = 0;
      hold_p = '0;
      hold_o = 1'b0;
    end else if (mt == 0) begin
      if (start) begin
        ma = opA;
        mb = opB;
        lat = lat_of(opB);
        mt = 1;
      end
    end else if (mt == lat) begin
      mt = 0;
    end else begin
      mt++;
      if (mt == lat) begin
        full = {16'h0, ma} * {16'h0, mb};
        hold_p = full[15:0];
        hold_o = (full > 32'h0000_FFFF);
      end
    end
  end

  always @(negedge clk) begin
    int          i;
    logic [31:0] mask;
    logic [31:0] pa;
    logic [31:0] mm;
    chk("busy", {31'h0, busy}, {31'h0, (mt != 0)});
    chk("done", {31'h0, done}, {31'h0, (mt != 0 && mt == lat)});
    chk("ctl", {28'h0, alu_Cin, alu_invA, alu_invB, alu_sign}, 32'h0);
    if (mt == 0 || mt == lat) begin
      chk("product", {16'h0, product}, {16'h0, hold_p});
      chk("ovf", {31'h0, ovf}, {31'h0, hold_o});
      chk("idle_op", {28'h0, alu_Op}, 32'h0);
      chk("idle_ab", {alu_A, alu_B}, 32'h0);
    end else if (mt % 2 == 1) begin
      i = (mt - 1) / 2;
      mask = (32'd1 << i) - 32'd1;
      pa = {16'h0, ma} * ({16'h0, mb} & mask);
      mm = {16'h0, ma} << i;
      chk("add_op", {28'h0, alu_Op}, 32'h4);
      chk("add_a", {16'h0, alu_A}, {16'h0, pa[15:0]});
      chk("add_b", {16'h0, alu_B}, {16'h0, mm[15:0]});
    end else begin
      i = (mt - 2) / 2;
      mm = {16'h0, ma} << i;
      chk("sll_op", {28'h0, alu_Op}, 32'h1);
      chk("sll_a", {16'h0, alu_A}, {16'h0, mm[15:0]});
      chk("sll_b", {16'h0, alu_B}, 32'h1);
    end
  end

  // one multiply with literal expectations; optional start poke at cycle poke
  task automatic run(input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] ep, input logic eo,
                     input int lat_off, input int lat_on, input int poke);
    int n;
    @(posedge clk); #1;
    opA = a;
    opB = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    opA = 16'h5555;
    opB = 16'hAAAA;
    n = 1;
    while (!done && n < 60) begin
      if (n == poke) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    chk("latency", n, EE ? lat_on : lat_off);
    chk("lit_product", {16'h0, product}, {16'h0, ep});
    chk("lit_ovf", {31'h0, ovf}, {31'h0, eo});
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_product", {16'h0, product}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(16'd3, 16'd5, 16'h000F, 1'b0, 33, 7, 0);
    run(16'h0100, 16'h0100, 16'h0000, 1'b1, 33, 19, 0);
    run(16'hFFFF, 16'd1, 16'hFFFF, 1'b0, 33, 3, 0);
    run(16'hFFFF, 16'd2, 16'hFFFE, 1'b1, 33, 5, 0);
    run(16'h1234, 16'd2, 16'h2468, 1'b0, 33, 5, 0);
    run(16'h1234, 16'd0, 16'h0000, 1'b0, 33, 3, 0);
    run(16'd0, 16'hFFFF, 16'h0000, 1'b0, 33, 33, 0);
    run(16'd3, 16'h8001, 16'h8003, 1'b1, 33, 33, 10);

    // reset in cycle 12 of an operation
    @(posedge clk); #1;
    opA = 16'd3;
    opB = 16'h8001;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (n < 12) begin
      @(posedge clk); #1;
      n++;
    end
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_done", {31'h0, done}, 32'h0);
    chk("mid_rst_product", {16'h0, product}, 32'h0);
    chk("mid_rst_ovf", {31'h0, ovf}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    run(16'd7, 16'd9, 16'h003F, 1'b0, 33, 9, 0);

    // random traffic, including starts while busy and rare resets
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      rst = ($urandom % 400 == 0);
      start = ($urandom % 4 == 0);
      case ($urandom % 4)
        0: begin
          opA = 16'($urandom % 256);
          opB = 16'($urandom % 256);
        end
        1: begin
          opA = 16'($urandom);
          opB = 16'($urandom % 8);
        end
        default: begin
          opA = 16'($urandom);
          opB = 16'($urandom);
        end
      endcase
    end
    @(posedge clk); #1;
    rst = 1'b0;
    start = 1'b0;
    n = 0;
    while (mt != 0 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", {31'h0, (mt != 0)}, 32'h0);
    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
